terrain_probe_scheduler: RTL and testbench
==========================================

# terrain_probe_scheduler

Owns the single map BRAM port and time-shares it between two requesters: the per-frame ball terrain probe and a low-priority auxiliary reader (minimap/HUD). On a `start_in` pulse it latches the 8.8 fixed-point ball position and issues five probe reads back-to-back: centre, x+½, x−½, y+½, y−½. It returns all five terrain codes together with a wall-edge mask, so gameplay needs one map memory instead of five.

## Interface
- `MAP_WIDTH`, 160: map width in tiles.
- `MAP_HEIGHT`, 90: map height in tiles.
- `PROBE_OFFSET`, 16'h0080: edge probe offset, 8.8 (0.5 tile).
- `INIT_FILE`, "map1.mem": map image, one 2-bit code per line, depth 65536.
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `start_in` in 1: one-cycle pulse to begin a probe sequence; honoured only when idle.
- `pos_x_in` in 16: ball x, 8.8 fixed point.
- `pos_y_in` in 16: ball y, 8.8 fixed point.
- `busy_out` out 1: probe sequence in progress.
- `done_out` out 1: one-cycle pulse when the result outputs have updated.
- `terrain_center_out`, `terrain_xplus_out`, `terrain_xminus_out`, `terrain_yplus_out`, `terrain_yminus_out` out 2 each: terrain codes.
- `edge_wall_out` out 4: bit0 x+, bit1 y+, bit2 x−, bit3 y−; set when that edge code == WALL.
- `aux_req_in` in 1: auxiliary read request; held high until granted.
- `aux_addr_in` in 16: auxiliary read address; not range-checked.
- `aux_gnt_out` out 1: pulse in the cycle `aux_addr_in` drives the RAM.
- `aux_rvalid_out` out 1: pulse 2 cycles after `aux_gnt_out`.
- `aux_data_out` out 2: auxiliary read data; valid with `aux_rvalid_out`.

## Operation
- Terrain codes: 0 HOLE, 1 WALL, 2 and 3 playable surfaces.
- States are IDLE, PROBE, DRAIN and DONE.
  - IDLE, with `start_in` high: latch the position and go to PROBE.
  - PROBE: five slots in fixed order C, X+, X−, Y+, Y−, one per cycle, then go to DRAIN.
  - DRAIN: two cycles, then DONE.
  - DONE: one cycle, then IDLE.
- Probe coordinates:
  - Tile x = (x ± PROBE_OFFSET)[15:8]; tile y likewise.
  - Compute in 17 bits.
  - A probe is out of bounds (OOB) on borrow (underflow), when tile x ≥ MAP_WIDTH, or when tile y ≥ MAP_HEIGHT.
- Address = tile_x + MAP_WIDTH·tile_y, computed at 16 bits with explicit parenthesisation.
- An OOB slot still consumes its cycle but leaves the RAM address unchanged. Its result is forced to WALL.
- A 2-deep tag pipeline carries {valid, source(probe/aux), slot index, oob} alongside the RAM latency. Returning data is steered by this tag.
- Arbitration:
  - A PROBE slot always owns the RAM.
  - In every other cycle, including the start-latch cycle, a pending `aux_req_in` is granted.
  - One aux grant per cycle at most.
- Result outputs are registered and update together on `done_out`. They hold between sequences.
- `start_in` while busy is ignored: no queueing, no effect on the current sequence.
- BRAM `rsta` is tied low.

## Timing
- Latencies, with `start_in` accepted at cycle T:
  - `busy_out` is high T+1 through T+8.
  - Probe slots drive the RAM at T+1..T+5.
  - Probe data returns at T+3..T+7.
  - `done_out` pulses at T+8.
  - The earliest next `start_in` that can be accepted is T+9.
- Aux read: grant at G, data at G+2. Maximum aux wait is 5 cycles.
- Reset values (all outputs 0):
  - Terrain outputs 0, `edge_wall_out` 0.
  - `busy_out`, `done_out`, `aux_gnt_out`, `aux_rvalid_out` 0; `aux_data_out` 0.
  - State IDLE; tag pipeline cleared.
- Reset asserted mid-sequence: in-flight reads are discarded and no `done_out` or `aux_rvalid_out` is produced for them.
- Reset deassertion: the first cycle after release may accept `start_in`.

## Structure
- Package `terrain_pkg` holds:
  - Terrain code enum (HOLE, WALL, …).
  - Probe slot enum (C, XP, XM, YP, YM), with edge order matching the `edge_wall_out` bits.
  - Scheduler state enum.
  - Tag struct.
- Sub-module: one `xilinx_single_port_ram_read_first` instance configured with RAM_WIDTH 2, RAM_DEPTH 65536, HIGH_PERFORMANCE, INIT_FILE.
- Address/OOB computation is combinational in the top level.

## Test plan
- Nominal probe: pos (0x0A00, 0x0A00), `start_in` → RAM addresses 1610, 1610, 1609, 1610, 1450 at T+1..T+5. `done_out` at T+8 and outputs equal the map codes.
- x underflow: pos_x 0x0040 → X− slot issues no new address; `terrain_xminus_out` = WALL and `edge_wall_out[2]` = 1.
- Bottom edge: pos_y 0x59C0 → Y+ tile 90 is OOB; `terrain_yplus_out` = WALL and `edge_wall_out[1]` = 1.
- Contention:
  - `aux_req_in` high with addr 1234 in the same cycle as `start_in` → `aux_gnt_out` at T, `aux_rvalid_out` at T+2 with map[1234].
  - An aux request raised at T+2 is granted at T+6.
- Restart and reset:
  - `start_in` at T+4 → ignored; a single `done_out` at T+8.
  - `rst_n_in` low at T+4 → all outputs 0, no `done_out`.
  - A fresh `start_in` after release completes normally.

Source files
------------

// File: rtl/terrain_pkg.sv
// rtl/terrain_pkg.sv - shared types for the terrain probe scheduler
package terrain_pkg;

    typedef enum logic [1:0] {
        TERRAIN_HOLE   = 2'd0,
        TERRAIN_WALL   = 2'd1,
        TERRAIN_SURF_A = 2'd2,
        TERRAIN_SURF_B = 2'd3
    } terrain_e;

    // Edge slots are numbered so that edge_wall_out bit = slot value - 1.
    typedef enum logic [2:0] {
        SLOT_C  = 3'd0,
        SLOT_XP = 3'd1,
        SLOT_YP = 3'd2,
        SLOT_XM = 3'd3,
        SLOT_YM = 3'd4
    } slot_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic  valid;
        logic  src_aux;
        slot_e slot;
        logic  oob;
    } probe_tag_t;

    // Issue order of the probe slots: C, X+, X-, Y+, Y-.
    function automatic slot_e slot_of_step(input logic [2:0] step);
        slot_e s;
        case (step)
            3'd0:    s = SLOT_C;
            3'd1:    s = SLOT_XP;
            3'd2:    s = SLOT_XM;
            3'd3:    s = SLOT_YP;
            default: s = SLOT_YM;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/xilinx_single_port_ram_read_first.sv
// rtl/xilinx_single_port_ram_read_first.sv - single-port read-first block RAM
module xilinx_single_port_ram_read_first #(
    parameter int RAM_WIDTH       = 2,
    parameter int RAM_DEPTH       = 65536,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter     INIT_FILE       = ""
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);

    logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    // The image named by INIT_FILE is attached to the array by the implementation flow.
    if (INIT_FILE != "") begin : g_init_image
    end

    // Read-first array access: the read returns the old contents on a write.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                bram[addra] <= dina;
            end
            ram_data <= bram[addra];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
        assign douta = ram_data;
    end else begin : g_out_reg
        logic [RAM_WIDTH-1:0] douta_reg;

        // Output register adds the second cycle of read latency.
        always_ff @(posedge clka) begin
            if (rsta) begin
                douta_reg <= '0;
            end else if (regcea) begin
                douta_reg <= ram_data;
            end
        end

        assign douta = douta_reg;
    end

endmodule

// File: rtl/terrain_probe_scheduler.sv
// rtl/terrain_probe_scheduler.sv - five-point terrain probe sharing one map RAM with an aux reader
module terrain_probe_scheduler
    import terrain_pkg::*;
#(
    parameter int          MAP_WIDTH    = 160,
    parameter int          MAP_HEIGHT   = 90,
    parameter logic [15:0] PROBE_OFFSET = 16'h0080,
    parameter              INIT_FILE    = "map1.mem"
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic [15:0] pos_x_in,
    input  logic [15:0] pos_y_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [1:0]  terrain_center_out,
    output logic [1:0]  terrain_xplus_out,
    output logic [1:0]  terrain_xminus_out,
    output logic [1:0]  terrain_yplus_out,
    output logic [1:0]  terrain_yminus_out,
    output logic [3:0]  edge_wall_out,
    input  logic        aux_req_in,
    input  logic [15:0] aux_addr_in,
    output logic        aux_gnt_out,
    output logic        aux_rvalid_out,
    output logic [1:0]  aux_data_out
);

    sched_state_e state;
    logic [2:0]   step;
    logic [15:0]  pos_x_q;
    logic [15:0]  pos_y_q;
    logic [15:0]  addr_q;
    slot_e        cur_slot;
    logic         probe_slot;
    logic [16:0]  cx;
    logic [16:0]  cy;
    logic [8:0]   tile_x;
    logic [8:0]   tile_y;
    logic         borrow;
    logic         probe_oob;
    logic [15:0]  probe_addr;
    logic [15:0]  ram_addr;
    logic [1:0]   ram_dout;
    probe_tag_t   tag_in;
    probe_tag_t   tag_d1;
    probe_tag_t   tag_d2;
    logic [1:0]   ret_code;
    logic [1:0]   stage_q [0:4];
    logic [1:0]   stage_d [0:4];

    assign probe_slot = (state == ST_PROBE);
    assign cur_slot   = slot_of_step(step);
    assign busy_out   = (state != ST_IDLE);
    assign done_out   = (state == ST_DONE);

    // Offset the latched position toward the current edge; bit 16 exposes carry and borrow.
    always_comb begin
        cx = {1'b0, pos_x_q};
        cy = {1'b0, pos_y_q};
        case (cur_slot)
            SLOT_XP: cx = {1'b0, pos_x_q} + {1'b0, PROBE_OFFSET};
            SLOT_XM: cx = {1'b0, pos_x_q} - {1'b0, PROBE_OFFSET};
            SLOT_YP: cy = {1'b0, pos_y_q} + {1'b0, PROBE_OFFSET};
            SLOT_YM: cy = {1'b0, pos_y_q} - {1'b0, PROBE_OFFSET};
            default: ;
        endcase
    end

    assign tile_x     = cx[16:8];
    assign tile_y     = cy[16:8];
    assign borrow     = ((cur_slot == SLOT_XM) && cx[16]) || ((cur_slot == SLOT_YM) && cy[16]);
    assign probe_oob  = borrow || (tile_x >= 9'(MAP_WIDTH)) || (tile_y >= 9'(MAP_HEIGHT));
    assign probe_addr = 16'(tile_x[7:0]) + (16'(MAP_WIDTH) * 16'(tile_y[7:0]));

    // Aux is served in any non-probe cycle; a request seen during reset waits for release.
    assign aux_gnt_out = aux_req_in && rst_n_in && !probe_slot;

    // RAM address mux: an OOB probe slot or an idle cycle repeats the previous address.
    always_comb begin
        ram_addr = addr_q;
        if (probe_slot) begin
            if (!probe_oob) begin
                ram_addr = probe_addr;
            end
        end else if (aux_gnt_out) begin
            ram_addr = aux_addr_in;
        end
    end

    // Tag describing who owns the read issued this cycle.
    always_comb begin
        tag_in = '0;
        if (probe_slot) begin
            tag_in.valid = 1'b1;
            tag_in.slot  = cur_slot;
            tag_in.oob   = probe_oob;
        end else if (aux_gnt_out) begin
            tag_in.valid   = 1'b1;
            tag_in.src_aux = 1'b1;
        end
    end

    // Sequencer: latch position, five probe slots, two drain cycles, one done cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= ST_IDLE;
            step    <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        pos_x_q <= pos_x_in;
                        pos_y_q <= pos_y_in;
                        step    <= '0;
                        state   <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    if (step == 3'd4) begin
                        step  <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (step == 3'd1) begin
                        step  <= '0;
                        state <= ST_DONE;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Last driven address and the tag pipeline matching the two-cycle RAM latency.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q <= '0;
            tag_d1 <= '0;
            tag_d2 <= '0;
        end else begin
            addr_q <= ram_addr;
            tag_d1 <= tag_in;
            tag_d2 <= tag_d1;
        end
    end

    assign ret_code       = tag_d2.oob ? TERRAIN_WALL : ram_dout;
    assign aux_rvalid_out = tag_d2.valid && tag_d2.src_aux;
    assign aux_data_out   = aux_rvalid_out ? ram_dout : 2'b00;

    // Steer returning probe data into its slot of the staging set.
    always_comb begin
        stage_d = stage_q;
        if (tag_d2.valid && !tag_d2.src_aux) begin
            stage_d[tag_d2.slot] = ret_code;
        end
    end

    // Staging capture, and a single joint update of the result outputs in the last drain cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 5; i++) begin
                stage_q[i] <= '0;
            end
            terrain_center_out <= '0;
            terrain_xplus_out  <= '0;
            terrain_xminus_out <= '0;
            terrain_yplus_out  <= '0;
            terrain_yminus_out <= '0;
            edge_wall_out      <= '0;
        end else begin
            stage_q <= stage_d;
            if ((state == ST_DRAIN) && (step == 3'd1)) begin
                terrain_center_out <= stage_d[SLOT_C];
                terrain_xplus_out  <= stage_d[SLOT_XP];
                terrain_xminus_out <= stage_d[SLOT_XM];
                terrain_yplus_out  <= stage_d[SLOT_YP];
                terrain_yminus_out <= stage_d[SLOT_YM];
                edge_wall_out      <= {stage_d[SLOT_YM] == TERRAIN_WALL,
                                       stage_d[SLOT_XM] == TERRAIN_WALL,
                                       stage_d[SLOT_YP] == TERRAIN_WALL,
                                       stage_d[SLOT_XP] == TERRAIN_WALL};
            end
        end
    end

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH       (2),
        .RAM_DEPTH       (65536),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
        .INIT_FILE       (INIT_FILE)
    ) u_map_ram (
        .addra  (ram_addr),
        .dina   (2'b00),
        .clka   (clk_in),
        .wea    (1'b0),
        .ena    (1'b1),
        .rsta   (1'b0),
        .regcea (1'b1),
        .douta  (ram_dout)
    );

endmodule

// File: tb/tb_terrain_probe_scheduler.sv
// tb/tb_terrain_probe_scheduler.sv - scoreboard bench for terrain_probe_scheduler
module tb_terrain_probe_scheduler;

    localparam int W   = 160;
    localparam int H   = 90;
    localparam int OFF = 128;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        start_in = 1'b0;
    logic [15:0] pos_x_in = '0;
    logic [15:0] pos_y_in = '0;
    logic        busy_out;
    logic        done_out;
    logic [1:0]  terrain_center_out;
    logic [1:0]  terrain_xplus_out;
    logic [1:0]  terrain_xminus_out;
    logic [1:0]  terrain_yplus_out;
    logic [1:0]  terrain_yminus_out;
    logic [3:0]  edge_wall_out;
    logic        aux_req_in = 1'b0;
    logic [15:0] aux_addr_in = '0;
    logic        aux_gnt_out;
    logic        aux_rvalid_out;
    logic [1:0]  aux_data_out;

    typedef struct packed {
        logic [1:0] c;
        logic [1:0] xp;
        logic [1:0] xm;
        logic [1:0] yp;
        logic [1:0] ym;
        logic [3:0] mask;
    } probe_exp_t;

    probe_exp_t exp_q[$];
    logic [1:0] aux_q[$];
    probe_exp_t last_exp;
    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;
    int done_cnt = 0;
    int done_cycle = -1;
    int rvalid_cnt = 0;

    terrain_probe_scheduler dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .start_in           (start_in),
        .pos_x_in           (pos_x_in),
        .pos_y_in           (pos_y_in),
        .busy_out           (busy_out),
        .done_out           (done_out),
        .terrain_center_out (terrain_center_out),
        .terrain_xplus_out  (terrain_xplus_out),
        .terrain_xminus_out (terrain_xminus_out),
        .terrain_yplus_out  (terrain_yplus_out),
        .terrain_yminus_out (terrain_yminus_out),
        .edge_wall_out      (edge_wall_out),
        .aux_req_in         (aux_req_in),
        .aux_addr_in        (aux_addr_in),
        .aux_gnt_out        (aux_gnt_out),
        .aux_rvalid_out     (aux_rvalid_out),
        .aux_data_out       (aux_data_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] map_code(input int a);
        return 2'((a ^ (a >> 3) ^ (a >> 6)) & 3);
    endfunction

    // idx: 0 C, 1 X+, 2 X-, 3 Y+, 4 Y-; returns -1 for an out-of-bounds probe.
    function automatic int exp_addr(input logic [15:0] x, input logic [15:0] y, input int idx);
        int px;
        int py;
        px = int'(x);
        py = int'(y);
        case (idx)
            1: px = px + OFF;
            2: px = px - OFF;
            3: py = py + OFF;
            4: py = py - OFF;
            default: ;
        endcase
        if (px < 0 || py < 0) return -1;
        if (px / 256 >= W || py / 256 >= H) return -1;
        return px / 256 + W * (py / 256);
    endfunction

    function automatic logic [1:0] exp_code(input logic [15:0] x, input logic [15:0] y, input int idx);
        int a;
        a = exp_addr(x, y, idx);
        return (a < 0) ? 2'd1 : map_code(a);
    endfunction

    function automatic probe_exp_t make_exp(input logic [15:0] x, input logic [15:0] y);
        probe_exp_t e;
        e.c    = exp_code(x, y, 0);
        e.xp   = exp_code(x, y, 1);
        e.xm   = exp_code(x, y, 2);
        e.yp   = exp_code(x, y, 3);
        e.ym   = exp_code(x, y, 4);
        e.mask = {e.ym == 2'd1, e.xm == 2'd1, e.yp == 2'd1, e.xp == 2'd1};
        return e;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial forever begin
        @(posedge clk_in);
        cycle++;
    end

    // Output monitor: pops the scoreboard on every done and aux return.
    initial forever begin
        @(negedge clk_in);
        if (done_out) begin
            done_cnt++;
            done_cycle = cycle;
            if (exp_q.size() == 0) begin
                check_eq("done_unexpected", 1, 0);
            end else begin
                last_exp = exp_q.pop_front();
                check_eq("res_center", terrain_center_out, last_exp.c);
                check_eq("res_xplus", terrain_xplus_out, last_exp.xp);
                check_eq("res_xminus", terrain_xminus_out, last_exp.xm);
                check_eq("res_yplus", terrain_yplus_out, last_exp.yp);
                check_eq("res_yminus", terrain_yminus_out, last_exp.ym);
                check_eq("res_edge_mask", edge_wall_out, last_exp.mask);
            end
        end
        if (aux_rvalid_out) begin
            rvalid_cnt++;
            if (aux_q.size() == 0) check_eq("rvalid_unexpected", 1, 0);
            else check_eq("aux_data", aux_data_out, aux_q.pop_front());
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy_out, 0);
        check_eq({tag, "_done"}, done_out, 0);
        check_eq({tag, "_terrain"}, {terrain_center_out, terrain_xplus_out, terrain_xminus_out,
                                     terrain_yplus_out, terrain_yminus_out}, 0);
        check_eq({tag, "_edge"}, edge_wall_out, 0);
        check_eq({tag, "_aux"}, {aux_gnt_out, aux_rvalid_out, aux_data_out}, 0);
    endtask

    // Drives one start at the current cycle T and walks T+1..T+10.
    task automatic run_probe(input logic [15:0] x, input logic [15:0] y, input int restart_at, input bit with_aux);
        int t;
        int d0;
        int prev;
        int a;
        int gnt_at;
        d0 = done_cnt;
        gnt_at = -1;
        prev = -1;
        pos_x_in = x;
        pos_y_in = y;
        start_in = 1'b1;
        if (with_aux) begin
            aux_req_in = 1'b1;
            aux_addr_in = 16'd1234;
            aux_q.push_back(map_code(1234));
        end
        t = cycle;
        exp_q.push_back(make_exp(x, y));
        #1;
        if (with_aux) check_eq("aux_gnt_at_start", aux_gnt_out, 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            start_in = 1'b0;
            if (with_aux && (k == 1 || gnt_at > 0)) aux_req_in = 1'b0;
            if (with_aux && k == 2) begin
                aux_req_in = 1'b1;
                aux_addr_in = 16'd4321;
                aux_q.push_back(map_code(4321));
            end
            if (k == restart_at) begin
                start_in = 1'b1;
                pos_x_in = ~x;
                pos_y_in = ~y;
            end
            #1;
            if (with_aux && aux_req_in && aux_gnt_out && gnt_at < 0) gnt_at = k;
            if (with_aux && (k == 2 || k == 8)) check_eq("aux_rvalid_timing", aux_rvalid_out, 1);
            if (k <= 5) begin
                a = exp_addr(x, y, k - 1);
                if (a < 0) a = prev;
                if (a >= 0) check_eq("probe_addr", dut.ram_addr, a);
                prev = a;
            end
            if (k == 1) check_eq("busy_t1", busy_out, 1);
            if (k == 8) check_eq("busy_t8", busy_out, 1);
            if (k == 9) check_eq("busy_t9", busy_out, 0);
        end
        aux_req_in = 1'b0;
        check_eq("done_count", done_cnt - d0, 1);
        check_eq("done_cycle", done_cycle, t + 8);
        if (with_aux) check_eq("aux_gnt_wait", gnt_at, 6);
    endtask

    initial begin
        int t;
        int d0;
        int r0;
        for (int a = 0; a < 65536; a++) begin
            dut.u_map_ram.bram[a] <= map_code(a);
        end
        repeat (3) step();
        check_all_zero("reset");
        rst_n_in = 1'b1;
        step();

        run_probe(16'h0A00, 16'h0A00, 0, 1'b0);
        step();
        check_eq("hold_center", terrain_center_out, last_exp.c);
        check_eq("hold_mask", edge_wall_out, last_exp.mask);

        run_probe(16'h0040, 16'h0A00, 0, 1'b0);
        check_eq("xminus_wall", terrain_xminus_out, 1);
        check_eq("edge_xm_bit", edge_wall_out[2], 1);

        run_probe(16'h0A00, 16'h59C0, 0, 1'b0);
        check_eq("yplus_wall", terrain_yplus_out, 1);
        check_eq("edge_yp_bit", edge_wall_out[1], 1);

        run_probe(16'h3C80, 16'h2140, 0, 1'b1);
        run_probe(16'h1234, 16'h0F70, 4, 1'b0);

        // Reset in the middle of a sequence.
        pos_x_in = 16'h1000;
        pos_y_in = 16'h1000;
        start_in = 1'b1;
        t = cycle;
        step();
        start_in = 1'b0;
        repeat (3) step();
        check_eq("mid_rst_cycle", cycle, t + 4);
        d0 = done_cnt;
        r0 = rvalid_cnt;
        rst_n_in = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (6) step();
        rst_n_in = 1'b1;
        step();
        check_eq("mid_rst_no_done", done_cnt - d0, 0);
        check_eq("mid_rst_no_rvalid", rvalid_cnt - r0, 0);
        run_probe(16'h5080, 16'h30C0, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_probe(16'($urandom_range(0, 16'hA200)), 16'($urandom_range(0, 16'h5C00)), 0, 1'b0);
        end

        repeat (4) step();
        check_eq("exp_q_empty", exp_q.size(), 0);
        check_eq("aux_q_empty", aux_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
